kb_cmd_tx: RTL and testbench

PS/2 host-to-device transmitter that sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It runs the full host request-to-send sequence, shifts out 8 data bits LSB first plus odd parity, then checks the device acknowledge. It drives the PS/2 lines open-drain through output-enable signals; the top level builds the tristate buffers. tx_idle connects to the rx_en input of the keyboard receiver so the receiver ignores lines while a command is in flight.

---
 rtl/kb_cmd_tx.sv | 173 +++++++++++++++++
 tb/tb_kb_cmd_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_cmd_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 8 data bits LSB first, odd parity, ack check.
// Optional device watchdog enabled by defining KB_TX_TIMEOUT_EN.
module kb_cmd_tx #(
  parameter int INHIBIT_CNT = 8192
`ifdef KB_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CNT = 1_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int IW = $clog2(INHIBIT_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_REL
  } state_t;

  state_t        state;
  logic [8:0]    sreg;
  logic [3:0]    bcnt;
  logic [IW-1:0] inh_cnt;
  logic [7:0]    filt;
  logic          fclk;
  logic          fclk_next;
  logic          fall_tick;
  logic          d_s1;
  logic          d_s2;

`ifdef KB_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CNT + 1);
  logic [WW-1:0] wdog;
`endif

  always_comb begin
    fclk_next = fclk;
    if (filt == '1)
      fclk_next = 1'b1;
    else if (filt == '0)
      fclk_next = 1'b0;
    fall_tick = fclk & ~fclk_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      fclk <= 1'b0;
      d_s1 <= 1'b0;
      d_s2 <= 1'b0;
    end else begin
      filt <= {ps2c_in, filt[7:1]};
      fclk <= fclk_next;
      d_s1 <= ps2d_in;
      d_s2 <= d_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      sreg         <= '0;
      bcnt         <= '0;
      inh_cnt      <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
`ifdef KB_TX_TIMEOUT_EN
      wdog         <= '0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_ps2) begin
            sreg    <= {~^din, din};
            ack_err <= 1'b0;
            bcnt    <= '0;
            inh_cnt <= '0;
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
            state   <= S_RTS;
          end
        end
        S_RTS: begin
          if (inh_cnt == IW'(INHIBIT_CNT - 1)) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            state   <= S_START;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end
        S_START: begin
          if (fall_tick) begin
            ps2d_oe <= ~sreg[0];
            bcnt    <= 4'd8;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          // ps2d_oe looks one bit ahead so the next bit appears right after this edge
          if (fall_tick) begin
            sreg <= {1'b0, sreg[8:1]};
            if (bcnt == 4'd0) begin
              ps2d_oe <= 1'b0;
              state   <= S_STOP;
            end else begin
              ps2d_oe <= ~sreg[1];
              bcnt    <= bcnt - 4'd1;
            end
          end
        end
        S_STOP: begin
          if (fall_tick) begin
            ack_err <= d_s2;
            state   <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: begin
          if (fclk && d_s2) begin
            tx_done_tick <= 1'b1;
            tx_idle      <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
`ifdef KB_TX_TIMEOUT_EN
      // watchdog assignments come last so an abort overrides the normal step
      if (state inside {S_START, S_DATA, S_STOP, S_WAIT_REL}) begin
        if (fall_tick) begin
          wdog <= '0;
        end else if (wdog == WW'(TIMEOUT_CNT - 1)) begin
          wdog         <= '0;
          ack_err      <= 1'b1;
          ps2c_oe      <= 1'b0;
          ps2d_oe      <= 1'b0;
          tx_done_tick <= 1'b1;
          tx_idle      <= 1'b1;
          state        <= S_IDLE;
        end else begin
          wdog <= wdog + WW'(1);
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_kb_cmd_tx.sv
// Self-checking bench for kb_cmd_tx: PS/2 device model on open-drain lines, randomized commands.
module tb_kb_cmd_tx;

  localparam int INH = 64;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_c;
  logic       dev_d;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  int checks = 0;
  int errors = 0;
  int half   = 30;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       start_bit;
    logic       start_oe;
    logic       lat;
    int         inh;
  } frame_t;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  kb_cmd_tx #(
    .INHIBIT_CNT(INH)
`ifdef KB_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CNT(TMO)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a write then plays the device side of the frame for n_edges clock pulses.
  task automatic run_frame(input logic [7:0] b, input bit ack, input int n_edges,
                           input int poke_edge, output frame_t f);
    int guard;
    f.data = '0; f.par = 1'b0; f.stop = 1'b0; f.start_bit = 1'b1;
    wr_ps2 = 1'b1;
    din    = b;
    cyc(1);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
    f.lat  = ps2c_oe;
    f.inh  = 0;
    guard  = 0;
    while (ps2c_oe === 1'b1 && guard < INH * 4) begin
      f.inh++;
      guard++;
      cyc(1);
    end
    f.start_oe = ps2d_oe;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) dev_d = 1'b0;
      cyc(half);
      if (e == 1) f.start_bit = ps2d_in;
      dev_c = 1'b0;
      cyc(half);
      if (e <= 8) f.data[e-1] = ps2d_in;
      else if (e == 9) f.par = ps2d_in;
      else if (e == 10) f.stop = ps2d_in;
      dev_c = 1'b1;
      if (e == poke_edge) begin
        wr_ps2 = 1'b1;
        din    = 8'h55;
        cyc(1);
        wr_ps2 = 1'b0;
      end
    end
    if (n_edges == 11) begin
      cyc(4);
      dev_d = 1'b1;
    end
  endtask

  task automatic wait_done(input int lim, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < lim) begin
      if (tx_done_tick === 1'b1) seen = 1'b1;
      else begin
        n++;
        cyc(1);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_ps2 = 1'b0; din = '0; dev_c = 1'b1; dev_d = 1'b1;
    cyc(3);
    checks++; if (ps2c_oe !== 1'b0) begin errors++; $display("FAIL rst_ps2c_oe got %b want 0", ps2c_oe); end
    checks++; if (ps2d_oe !== 1'b0) begin errors++; $display("FAIL rst_ps2d_oe got %b want 0", ps2d_oe); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL rst_tx_idle got %b want 1", tx_idle); end
    checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", tx_done_tick); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b want 0", ack_err); end
    reset = 1'b0;
    cyc(12);
  endtask

  task automatic test_led_cmd;
    frame_t f; bit seen; int n;
    run_frame(8'hED, 1'b1, 11, 0, f);
    wait_done(300, seen, n);
    checks++; if (f.lat !== 1'b1) begin errors++; $display("FAIL led_latency ps2c_oe got %b want 1", f.lat); end
    checks++; if (f.start_bit !== 1'b0) begin errors++; $display("FAIL led_start got %b want 0", f.start_bit); end
    checks++; if (f.data !== 8'hED) begin errors++; $display("FAIL led_data got %h want ed", f.data); end
    checks++; if (f.par !== 1'b1) begin errors++; $display("FAIL led_parity got %b want 1", f.par); end
    checks++; if (f.stop !== 1'b1) begin errors++; $display("FAIL led_stop got %b want 1", f.stop); end
    checks++; if (!seen) begin errors++; $display("FAIL led_done got none want pulse"); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL led_ack_err got %b want 0", ack_err); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL led_idle got %b want 1", tx_idle); end
    cyc(1);
    checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL led_done_width got %b want 0", tx_done_tick); end
    cyc(5);
  endtask

  task automatic test_back_to_back;
    frame_t f; bit seen; int n;
    logic [7:0] bytes [2];
    bytes[0] = 8'h01;
    bytes[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      run_frame(bytes[k], 1'b1, 11, 0, f);
      wait_done(300, seen, n);
      checks++; if (f.data !== bytes[k]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", k, f.data, bytes[k]); end
      checks++; if (f.par !== odd_par(bytes[k])) begin errors++; $display("FAIL b2b_parity%0d got %b want %b", k, f.par, odd_par(bytes[k])); end
      checks++; if (!seen || ack_err !== 1'b0) begin errors++; $display("FAIL b2b_ack%0d got done=%b ack_err=%b want done=1 ack_err=0", k, seen, ack_err); end
      cyc(1);
    end
    cyc(5);
  endtask

  task automatic test_inhibit;
    frame_t f; bit seen; int n;
    run_frame(8'h00, 1'b1, 11, 0, f);
    wait_done(300, seen, n);
    checks++; if (f.inh != INH) begin errors++; $display("FAIL inh_len got %0d want %0d", f.inh, INH); end
    checks++; if (f.start_oe !== 1'b1) begin errors++; $display("FAIL inh_d_rise got %b want 1", f.start_oe); end
    checks++; if (f.par !== 1'b1) begin errors++; $display("FAIL inh_parity got %b want 1", f.par); end
    checks++; if (!seen) begin errors++; $display("FAIL inh_done got none want pulse"); end
    cyc(5);
  endtask

  task automatic test_no_ack;
    frame_t f; bit seen; int n;
    logic [7:0] b;
    b = 8'($urandom);
    run_frame(b, 1'b0, 11, 0, f);
    wait_done(300, seen, n);
    checks++; if (!seen || ack_err !== 1'b1) begin errors++; $display("FAIL nack_err got done=%b ack_err=%b want done=1 ack_err=1", seen, ack_err); end
    cyc(20);
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_hold got %b want 1", ack_err); end
    run_frame(8'hF4, 1'b1, 11, 0, f);
    wait_done(300, seen, n);
    checks++; if (f.data !== 8'hF4) begin errors++; $display("FAIL nack_next_data got %h want f4", f.data); end
    checks++; if (!seen || ack_err !== 1'b0) begin errors++; $display("FAIL nack_clear got done=%b ack_err=%b want done=1 ack_err=0", seen, ack_err); end
    cyc(5);
  endtask

  task automatic test_ignored_write;
    frame_t f; bit seen; int n;
    run_frame(8'hED, 1'b1, 11, 5, f);
    wait_done(300, seen, n);
    checks++; if (f.data !== 8'hED || f.par !== 1'b1) begin errors++; $display("FAIL ign_data got %h/%b want ed/1", f.data, f.par); end
    checks++; if (!seen) begin errors++; $display("FAIL ign_done got none want pulse"); end
    cyc(INH + 20);
    checks++; if (ps2c_oe !== 1'b0 || tx_idle !== 1'b1) begin errors++; $display("FAIL ign_restart got c_oe=%b idle=%b want 0/1", ps2c_oe, tx_idle); end
  endtask

  task automatic test_reset_mid;
    frame_t f; int dones;
    run_frame(8'hA5, 1'b1, 4, 0, f);
    reset = 1'b1;
    #1;
    checks++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin errors++; $display("FAIL rmid_lines got c=%b d=%b want 0/0", ps2c_oe, ps2d_oe); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b want 1", tx_idle); end
    cyc(2);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_done_tick === 1'b1) dones++;
      cyc(1);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rmid_done got %0d want 0", dones); end
  endtask

  task automatic test_random;
    frame_t f; bit seen; int n;
    logic [7:0] b; bit ack;
    for (int k = 0; k < 6; k++) begin
      b    = 8'($urandom);
      ack  = 1'($urandom);
      half = int'($urandom_range(20, 40));
      run_frame(b, ack, 11, 0, f);
      wait_done(300, seen, n);
      checks++; if (f.data !== b || f.par !== odd_par(b) || f.stop !== 1'b1) begin
        errors++; $display("FAIL rnd_frame%0d got %h/%b/%b want %h/%b/1", k, f.data, f.par, f.stop, b, odd_par(b));
      end
      checks++; if (!seen || ack_err !== !ack) begin
        errors++; $display("FAIL rnd_ack%0d got done=%b ack_err=%b want done=1 ack_err=%b", k, seen, ack_err, !ack);
      end
      cyc(int'($urandom_range(1, 10)));
    end
    half = 30;
  endtask

`ifdef KB_TX_TIMEOUT_EN
  task automatic test_timeout;
    frame_t f; bit seen; int n;
    run_frame(8'hED, 1'b1, 3, 0, f);
    wait_done(TMO + 200, seen, n);
    // fall_tick follows the physical edge by the 8-sample filter
    checks++; if (!seen || (n + half) < TMO + 1 || (n + half) > TMO + 15) begin
      errors++; $display("FAIL tmo_time got done=%b after %0d cycles want %0d..%0d", seen, n + half, TMO + 1, TMO + 15);
    end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL tmo_ack_err got %b want 1", ack_err); end
    checks++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || tx_idle !== 1'b1) begin
      errors++; $display("FAIL tmo_release got c=%b d=%b idle=%b want 0/0/1", ps2c_oe, ps2d_oe, tx_idle);
    end
    cyc(20);
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_led_cmd();
    test_back_to_back();
    test_inhibit();
    test_no_ack();
    test_ignored_write();
    test_reset_mid();
    test_random();
`ifdef KB_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
